// File: rtl/stream_packetizer.sv
// rtl/stream_packetizer.sv - N-channel sample framer with byte FIFO and UART start/busy pacer.
// Option macro: STREAM_PACKETIZER_CHECKSUM_EN appends a two's-complement checksum byte.
module stream_packetizer #(
    parameter int N_CH            = 4,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int FIFO_ADDR_WIDTH = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_strobe,
    input  logic [N_CH*SAMPLE_WIDTH-1:0] i_data,
    input  logic [7:0]                   i_id,
    input  logic [7:0]                   i_div,
    input  logic                         i_clr_overrun,
    input  logic                         i_tx_busy,
    output logic                         o_tx_start,
    output logic [7:0]                   o_tx_byte,
    output logic                         o_busy,
    output logic                         o_overrun
);
    localparam int DW    = N_CH * SAMPLE_WIDTH;
    localparam int P     = DW / 8;
    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [6:0] P_LAST = 7'(P - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_ID, S_SEQ, S_PAY
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t                     state;
    logic [DW-1:0]              shadow;
    logic [7:0]                 id_q;
    logic [7:0]                 seq;
    logic [7:0]                 dcnt;
    logic [6:0]                 pay_cnt;
    logic                       tx_wait;
    logic                       pop_q;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_ADDR_WIDTH:0]   wr_ptr;
    logic [FIFO_ADDR_WIDTH:0]   rd_ptr;
    logic [7:0]                 push_byte;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
    logic [7:0]                 csum_acc;
`endif

    logic full, empty, push, pop, last_byte, stb, selected, framer_free, accept, drop;

    assign full  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                   (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = (state != S_IDLE) && !full;
    assign pop   = !empty && !i_tx_busy && !tx_wait;

`ifdef STREAM_PACKETIZER_CHECKSUM_EN
    assign last_byte = (state == S_CSUM);
`else
    assign last_byte = (state == S_PAY) && (pay_cnt == P_LAST);
`endif

    // A strobe landing on the edge that writes the final byte is accepted.
    assign stb         = i_strobe && i_en;
    assign selected    = stb && (dcnt == i_div);
    assign framer_free = (state == S_IDLE) || (last_byte && push);
    assign accept      = selected && framer_free;
    assign drop        = selected && !framer_free;

    always_comb begin
        push_byte = 8'hA5;
        case (state)
            S_HDR1: push_byte = 8'h5A;
            S_ID:   push_byte = id_q;
            S_SEQ:  push_byte = seq;
            S_PAY:  push_byte = shadow[DW-1 -: 8];
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
            S_CSUM: push_byte = 8'h00 - csum_acc;
`endif
            default: push_byte = 8'hA5;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= push_byte;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            shadow     <= '0;
            id_q       <= 8'h00;
            seq        <= 8'h00;
            dcnt       <= 8'h00;
            pay_cnt    <= 7'd0;
            tx_wait    <= 1'b0;
            pop_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_tx_start <= 1'b0;
            o_tx_byte  <= 8'h00;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
            csum_acc   <= 8'h00;
`endif
        end else begin
            if (stb) dcnt <= selected ? 8'h00 : dcnt + 8'h01;

            if (drop)               o_overrun <= 1'b1;
            else if (i_clr_overrun) o_overrun <= 1'b0;

            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                o_tx_byte <= mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
                tx_wait   <= 1'b1;
            end else if (i_tx_busy) begin
                tx_wait   <= 1'b0;
            end
            pop_q      <= pop;
            o_tx_start <= pop_q;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
                if (state == S_ID || state == S_SEQ || state == S_PAY)
                    csum_acc <= csum_acc + push_byte;
`endif
                case (state)
                    S_HDR0: state <= S_HDR1;
                    S_HDR1: state <= S_ID;
                    S_ID:   state <= S_SEQ;
                    S_SEQ: begin
                        state   <= S_PAY;
                        pay_cnt <= 7'd0;
                    end
                    S_PAY: begin
                        shadow  <= shadow << 8;
                        pay_cnt <= pay_cnt + 7'd1;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
                        if (pay_cnt == P_LAST) state <= S_CSUM;
`endif
                    end
                    default: state <= state;
                endcase
                if (last_byte) begin
                    seq    <= seq + 8'h01;
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            end

            if (accept) begin
                shadow   <= i_data;
                id_q     <= i_id;
                state    <= S_HDR0;
                o_busy   <= 1'b1;
`ifdef STREAM_PACKETIZER_CHECKSUM_EN
                csum_acc <= 8'h00;
`endif
            end
        end
    end
endmodule
